// File: rtl/histo_readout.sv
// rtl/histo_readout.sv - streams every histogram bin from a DPRAM and totals them into frame_sum.
// Optional HISTO_CLEAR_ON_READ_EN zeroes each bin as the sink accepts it.
module histo_readout #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 32,
   parameter int NUM_BINS = 1024
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   output logic [ADDR_W-1:0]        ram_addr,
   output logic                     ram_we,
   output logic [DATA_W-1:0]        ram_wdata,
   input  logic [DATA_W-1:0]        ram_rdata,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_last,
   output logic                     busy,
   output logic                     done,
   output logic [DATA_W+ADDR_W-1:0] frame_sum
);

   localparam int SUM_W = DATA_W + ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BINS - 1);

   typedef enum logic [2:0] {IDLE, RD, WT, XFER, FIN} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  index_q, index_d;
   logic [SUM_W-1:0]   sum_q, sum_d;
   logic [SUM_W-1:0]   frame_sum_q, frame_sum_d;
   logic [DATA_W-1:0]  out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic               out_last_q, out_last_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               accept;

   assign accept = (state_q == XFER) && out_ready;

   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      sum_d       = sum_q;
      frame_sum_d = frame_sum_q;
      out_data_d  = out_data_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               index_d = '0;
               sum_d   = '0;
               state_d = RD;
            end
         end
         RD:   state_d = WT;
         WT: begin
            out_data_d = ram_rdata;
            state_d    = XFER;
         end
         XFER: begin
            if (accept) begin
               sum_d = sum_q + SUM_W'(out_data_q);
               if (index_q == LAST_IDX) begin
                  state_d = FIN;
               end else begin
                  index_d = index_q + ADDR_W'(1);
                  state_d = RD;
               end
            end
         end
         FIN: begin
            frame_sum_d = sum_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Status outputs are registered from the next-state decode so they line up with the state.
      out_valid_d = (state_d == XFER);
      out_last_d  = (state_d == XFER) && (index_d == LAST_IDX);
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == FIN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         index_q     <= '0;
         sum_q       <= '0;
         frame_sum_q <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         sum_q       <= sum_d;
         frame_sum_q <= frame_sum_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

`ifdef HISTO_CLEAR_ON_READ_EN
   // The write must coincide with the handshake, so it cannot wait for a register stage.
   assign ram_we = accept && !reset;
`else
   assign ram_we = 1'b0;
`endif

   assign ram_addr  = index_q;
   assign ram_wdata = '0;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign frame_sum = frame_sum_q;

endmodule

// File: doc/histo_readout.md
HISTO_READOUT -- requirements
Module: histo_readout

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, bin address width.
REQ-002 SHALL have parameter DATA_W, default 32, bin count width.
REQ-003 SHALL have parameter NUM_BINS, default 1024, bins read per frame (≤ 2^ADDR_W).
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse requesting a full-histogram readout.
REQ-007 SHALL have port ram_addr  output  ADDR_W  address to the DPRAM read/write port.
REQ-008 SHALL have port ram_we  output  1  write enable to the same DPRAM port.
REQ-009 SHALL have port ram_wdata  output  DATA_W  write data to the DPRAM; always zero.
REQ-010 SHALL have port ram_rdata  input  DATA_W  registered DPRAM read data, valid one cycle after ram_addr.
REQ-011 SHALL have port out_valid  output  1  stream data valid.
REQ-012 SHALL have port out_ready  input  1  stream sink ready.
REQ-013 SHALL have port out_data  output  DATA_W  bin count.
REQ-014 SHALL have port out_last  output  1  marks bin NUM_BINS-1.
REQ-015 SHALL have port busy  output  1  readout in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the last bin is accepted.
REQ-017 SHALL have port frame_sum  output  DATA_W+ADDR_W  sum of all bins streamed in the last completed readout.

Function
REQ-018 SHALL implement states IDLE, RD, WT, XFER, FIN.
REQ-019 IDLE: start=1 SHALL clear the bin index and running sum, then go to RD; start=0 SHALL stay in IDLE.
REQ-020 RD: SHALL drive ram_addr=index, ram_we=0, then go to WT.
REQ-021 WT: SHALL capture ram_rdata into out_data, then go to XFER.
REQ-022 XFER: SHALL hold out_valid=1 and hold out_data stable until out_valid&out_ready; a stall of any length SHALL be tolerated.
REQ-023 On acceptance, SHALL add out_data to the running sum with zero-extension; with NUM_BINS ≤ 2^ADDR_W the sum cannot overflow.
REQ-024 On acceptance with index < NUM_BINS-1, SHALL increment the index and go to RD.
REQ-025 On acceptance with index = NUM_BINS-1, SHALL go to FIN.
REQ-026 out_last SHALL be 1 only while in XFER with index = NUM_BINS-1.
REQ-027 FIN: SHALL pulse done for one cycle, load frame_sum from the running sum, and return to IDLE.
REQ-028 busy SHALL be 1 in every state other than IDLE.
REQ-029 start asserted while busy=1 SHALL be ignored; start in the FIN cycle SHALL also be ignored.
REQ-030 Latency SHALL be: first out_valid 3 cycles after the start cycle; with out_ready held high, one bin every 3 cycles.
REQ-031 frame_sum SHALL hold its value until the next FIN.

Reset
REQ-032 reset=1 SHALL force state=IDLE and SHALL clear out_valid, out_last, busy, done, ram_we, ram_addr, out_data and frame_sum to 0.
REQ-033 reset asserted mid-readout SHALL abort with no further RAM write and no done pulse; a partial sum SHALL NOT reach frame_sum.
REQ-034 reset SHALL take priority over start in the same cycle.

Configuration
REQ-035 Macro HISTO_CLEAR_ON_READ_EN defined: on each XFER acceptance, SHALL assert ram_we=1 for exactly that cycle with ram_addr=index and ram_wdata=0, clearing the bin.
REQ-036 Macro HISTO_CLEAR_ON_READ_EN undefined: ram_we SHALL be constant 0 and the histogram SHALL be left unchanged.

Verification
REQ-037 Preload bins with value = address, out_ready=1, pulse start -> 1024 beats with data 0..1023 in order, out_last on beat 1023 only, done one cycle after, frame_sum=523776.
REQ-038 Hold out_ready=0 for 20 cycles at bin 5 -> out_valid held, out_data stays 5, no index advance; release -> stream resumes with bin 6.
REQ-039 With HISTO_CLEAR_ON_READ_EN, all bins=0xFFFFFFFF, run readout, then run again -> second frame all zeros, frame_sum=0; first frame frame_sum=0x3FFFFFFFC00.
REQ-040 Pulse start at beat 100 of an active readout -> ignored; exactly 1024 beats and one done pulse.
REQ-041 Assert reset at beat 300 -> next cycle busy=0, out_valid=0, ram_we=0, frame_sum=0; a new start then streams from bin 0.
REQ-042 Without HISTO_CLEAR_ON_READ_EN, full readout -> ram_we never 1; RAM contents unchanged.
